// File: rtl/core_pkg.sv
// Shared core definitions: hazard-control FSM states, divider wait default and
// register-index width.
package core_pkg;

  localparam int REG_IDX_W       = 5;
  localparam int DIV_MAX_CYC_DEF = 34;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_REDIRECT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: flags an ID source that depends on a
// load still sitting in EXE.
module load_use_detect
  import core_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rsA_i,
  input  logic [REG_IDX_W-1:0] id_rsB_i,
  input  logic                 id_use_rsA_i,
  input  logic                 id_use_rsB_i,
  input  logic [REG_IDX_W-1:0] exe_rd_i,
  input  logic                 exe_wr_en_i,
  input  logic                 exe_is_load_i,
  output logic                 hazard_o
);

  logic match_a;
  logic match_b;

  assign match_a = id_use_rsA_i & (id_rsA_i == exe_rd_i);
  assign match_b = id_use_rsB_i & (id_rsB_i == exe_rd_i);

  // x0 is hardwired zero, so a load targeting it never produces a dependency.
  assign hazard_o = exe_is_load_i & exe_wr_en_i & (exe_rd_i != '0) & (match_a | match_b);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush control for the 5-stage pipeline (load-use, redirect, divide wait).
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int DIV_MAX_CYC = DIV_MAX_CYC_DEF,
  parameter int PERF_W      = 32
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [REG_IDX_W-1:0] id_rsA,
  input  logic [REG_IDX_W-1:0] id_rsB,
  input  logic                 id_use_rsA,
  input  logic                 id_use_rsB,
  input  logic [REG_IDX_W-1:0] exe_rd,
  input  logic                 exe_wr_en,
  input  logic                 exe_is_load,
  input  logic                 exe_br_taken,
  input  logic                 exe_div_start,
  input  logic                 div_done,
  output logic                 if_stall,
  output logic                 id_stall,
  output logic                 exe_stall,
  output logic                 if_id_flush,
  output logic                 id_exe_flush,
  output logic                 exe_mem_flush,
  output logic                 div_timeout,
  output logic [1:0]           state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]    perf_stall_cyc,
  output logic [PERF_W-1:0]    perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(DIV_MAX_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_MAX_CYC);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             lu_hazard;

  logic ifs_c, ids_c, exs_c, ifidf_c, idexf_c, exmemf_c;

  load_use_detect u_lud (
    .id_rsA_i      (id_rsA),
    .id_rsB_i      (id_rsB),
    .id_use_rsA_i  (id_use_rsA),
    .id_use_rsB_i  (id_use_rsB),
    .exe_rd_i      (exe_rd),
    .exe_wr_en_i   (exe_wr_en),
    .exe_is_load_i (exe_is_load),
    .hazard_o      (lu_hazard)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    ifs_c    = 1'b0;
    ids_c    = 1'b0;
    exs_c    = 1'b0;
    ifidf_c  = 1'b0;
    idexf_c  = 1'b0;
    exmemf_c = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (exe_br_taken) begin
          ifidf_c = 1'b1;
          idexf_c = 1'b1;
          state_d = ST_REDIRECT;
        end else if (exe_div_start) begin
          ifs_c    = 1'b1;
          ids_c    = 1'b1;
          exs_c    = 1'b1;
          exmemf_c = 1'b1;
          cnt_d    = CNT_W'(1);
          state_d  = ST_DIV_WAIT;
        end else if (lu_hazard) begin
          ifs_c   = 1'b1;
          ids_c   = 1'b1;
          idexf_c = 1'b1;
        end
      end
      // The synchronous imem still delivers one wrong-path fetch after a redirect.
      ST_REDIRECT: begin
        ifidf_c = 1'b1;
        state_d = ST_RUN;
      end
      ST_DIV_WAIT: begin
        if (div_done) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          ifs_c    = 1'b1;
          ids_c    = 1'b1;
          exs_c    = 1'b1;
          exmemf_c = 1'b1;
          cnt_d    = (cnt_q >= CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          if (cnt_d >= CNT_MAX) tmo_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Outputs are forced low while reset is asserted so no stale stall escapes.
  assign if_stall      = nrst & ifs_c;
  assign id_stall      = nrst & ids_c;
  assign exe_stall     = nrst & exs_c;
  assign if_id_flush   = nrst & ifidf_c;
  assign id_exe_flush  = nrst & idexf_c;
  assign exe_mem_flush = nrst & exmemf_c;
  assign div_timeout   = tmo_q;
  assign state         = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cyc_q;
  logic [PERF_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (if_stall) stall_cyc_q <= stall_cyc_q + PERF_W'(1);
      if ((state_q == ST_RUN) && exe_br_taken) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign perf_stall_cyc = stall_cyc_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  // Performance counters compiled out.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: table of single-cycle load-use vectors plus
// hand-written redirect, divide, timeout and reset sequences.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       nrst;
  logic [4:0] id_rsA, id_rsB, exe_rd;
  logic       id_use_rsA, id_use_rsB, exe_wr_en, exe_is_load;
  logic       exe_br_taken, exe_div_start, div_done;
  logic       if_stall, id_stall, exe_stall, if_id_flush, id_exe_flush, exe_mem_flush;
  logic       div_timeout;
  logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

  int tot = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk           (clk),
    .nrst          (nrst),
    .id_rsA        (id_rsA),
    .id_rsB        (id_rsB),
    .id_use_rsA    (id_use_rsA),
    .id_use_rsB    (id_use_rsB),
    .exe_rd        (exe_rd),
    .exe_wr_en     (exe_wr_en),
    .exe_is_load   (exe_is_load),
    .exe_br_taken  (exe_br_taken),
    .exe_div_start (exe_div_start),
    .div_done      (div_done),
    .if_stall      (if_stall),
    .id_stall      (id_stall),
    .exe_stall     (exe_stall),
    .if_id_flush   (if_id_flush),
    .id_exe_flush  (id_exe_flush),
    .exe_mem_flush (exe_mem_flush),
    .div_timeout   (div_timeout),
    .state         (state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cyc(perf_stall_cyc),
    .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  // Output order: {if_stall, id_stall, exe_stall, if_id_flush, id_exe_flush, exe_mem_flush}
  localparam logic [5:0] O_NONE = 6'b000000;
  localparam logic [5:0] O_LU   = 6'b110010;
  localparam logic [5:0] O_BR   = 6'b000110;
  localparam logic [5:0] O_RDR  = 6'b000100;
  localparam logic [5:0] O_DIV  = 6'b111001;

  typedef struct {
    logic [4:0] rsA, rsB, rd;
    logic       useA, useB, wr, ld;
    logic [5:0] exp;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    tot++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_cyc(input string nm, input logic [5:0] eo, input logic [1:0] es,
                         input logic et);
    chk({nm, "/outs"}, int'({if_stall, id_stall, exe_stall, if_id_flush, id_exe_flush,
                             exe_mem_flush}), int'(eo));
    chk({nm, "/state"}, int'(state), int'(es));
    chk({nm, "/tmo"}, int'(div_timeout), int'(et));
  endtask

  task automatic idle();
    id_rsA = 0; id_rsB = 0; id_use_rsA = 0; id_use_rsB = 0;
    exe_rd = 0; exe_wr_en = 0; exe_is_load = 0;
    exe_br_taken = 0; exe_div_start = 0; div_done = 0;
  endtask

  task automatic set_lu();
    exe_rd = 5; exe_wr_en = 1; exe_is_load = 1;
    id_rsA = 5; id_use_rsA = 1;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{rsA:5, rsB:0, rd:5, useA:1, useB:0, wr:1, ld:1, exp:O_LU};
    vecs[1] = '{rsA:0, rsB:0, rd:0, useA:1, useB:1, wr:1, ld:1, exp:O_NONE};
    vecs[2] = '{rsA:5, rsB:0, rd:5, useA:0, useB:0, wr:1, ld:1, exp:O_NONE};
    vecs[3] = '{rsA:1, rsB:7, rd:7, useA:1, useB:1, wr:1, ld:1, exp:O_LU};
    vecs[4] = '{rsA:5, rsB:5, rd:5, useA:1, useB:1, wr:1, ld:0, exp:O_NONE};
    vecs[5] = '{rsA:5, rsB:5, rd:5, useA:1, useB:1, wr:0, ld:1, exp:O_NONE};
    vecs[6] = '{rsA:5, rsB:4, rd:6, useA:1, useB:1, wr:1, ld:1, exp:O_NONE};
    vecs[7] = '{rsA:9, rsB:9, rd:9, useA:0, useB:1, wr:1, ld:1, exp:O_LU};
    vecs[8] = '{rsA:31, rsB:31, rd:31, useA:1, useB:0, wr:1, ld:1, exp:O_LU};

    // Reset: outputs held low even with a hazard present
    idle();
    nrst = 0;
    set_lu();
    exe_br_taken = 1;
    @(negedge clk);
    chk("rst_gate/outs", int'({if_stall, id_stall, id_exe_flush, if_id_flush}), 0);
    next_cyc();
    idle();
    @(negedge clk);
    chk_cyc("rst_state", O_NONE, 2'd0, 1'b0);
    next_cyc();
    nrst = 1;

    // Table: single-cycle load-use vectors, state stays RUN
    for (int i = 0; i < 9; i++) begin
      id_rsA = vecs[i].rsA; id_rsB = vecs[i].rsB; exe_rd = vecs[i].rd;
      id_use_rsA = vecs[i].useA; id_use_rsB = vecs[i].useB;
      exe_wr_en = vecs[i].wr; exe_is_load = vecs[i].ld;
      @(negedge clk);
      chk_cyc($sformatf("vec%0d", i), vecs[i].exp, 2'd0, 1'b0);
      next_cyc();
    end
    idle();
    @(negedge clk);
    chk_cyc("lu_after", O_NONE, 2'd0, 1'b0);
    next_cyc();

    // Branch redirect; REDIRECT cycle ignores a hazard and another branch
    exe_br_taken = 1;
    @(negedge clk);
    chk_cyc("br_t0", O_BR, 2'd0, 1'b0);
    next_cyc();
    set_lu();
    exe_br_taken = 1;
    @(negedge clk);
    chk_cyc("br_t1", O_RDR, 2'd2, 1'b0);
    next_cyc();
    idle();
    @(negedge clk);
    chk_cyc("br_t2", O_NONE, 2'd0, 1'b0);
    next_cyc();

    // Divide with done at t+10; branch during wait is ignored
    exe_div_start = 1;
    set_lu();
    @(negedge clk);
    chk_cyc("div_t0", O_DIV, 2'd0, 1'b0);
    next_cyc();
    idle();
    for (int k = 1; k <= 9; k++) begin
      exe_br_taken = (k == 4);
      exe_div_start = (k == 5);
      @(negedge clk);
      chk_cyc($sformatf("div_t%0d", k), O_DIV, 2'd1, 1'b0);
      next_cyc();
    end
    idle();
    div_done = 1;
    @(negedge clk);
    chk_cyc("div_t10", O_NONE, 2'd1, 1'b0);
    next_cyc();
    idle();
    @(negedge clk);
    chk_cyc("div_t11", O_NONE, 2'd0, 1'b0);
    next_cyc();

    // Divide timeout: sets once the counter reaches 34, stalling continues
    exe_div_start = 1;
    @(negedge clk);
    chk_cyc("tmo_t0", O_DIV, 2'd0, 1'b0);
    next_cyc();
    idle();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk_cyc($sformatf("tmo_t%0d", k), O_DIV, 2'd1, (k >= 34));
      next_cyc();
    end
    nrst = 0;
    @(negedge clk);
    chk_cyc("tmo_rst_in", O_NONE, 2'd1, 1'b1);
    next_cyc();
    nrst = 1;
    @(negedge clk);
    chk_cyc("tmo_rst_out", O_NONE, 2'd0, 1'b0);
    next_cyc();

    // Reset in the middle of REDIRECT
    exe_br_taken = 1;
    next_cyc();
    idle();
    nrst = 0;
    @(negedge clk);
    chk_cyc("rdr_rst_in", O_NONE, 2'd2, 1'b0);
    next_cyc();
    nrst = 1;
    @(negedge clk);
    chk_cyc("rdr_rst_out", O_NONE, 2'd0, 1'b0);
    next_cyc();

    // Simultaneous branch + divide + load-use: branch wins
    set_lu();
    exe_br_taken = 1;
    exe_div_start = 1;
    @(negedge clk);
    chk_cyc("sim_t0", O_BR, 2'd0, 1'b0);
    next_cyc();
    idle();
    @(negedge clk);
    chk_cyc("sim_t1", O_RDR, 2'd2, 1'b0);
    next_cyc();
    @(negedge clk);
    chk_cyc("sim_t2", O_NONE, 2'd0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_flush", int'(perf_flush_cnt), 1);
    chk("perf_stall", int'(perf_stall_cyc), 0);
`endif

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
